// File: rtl/cpu_types_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Basic CPU-side data types shared by the memory subsystem:
//               the 32-bit machine word and the RAM handshake state.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // ERROR is reported by the RAM model but the arbiter treats it as BUSY.
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage
`default_nettype wire

// File: rtl/diaosi_types_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : diaosi_types_pkg
// Description : Types for the multicore memory subsystem glue logic,
//               currently the coherence arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package diaosi_types_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SNOOP0 = 3'd1,
    SNOOP1 = 3'd2,
    CCWB   = 3'd3,
    DSERVE = 3'd4,
    ISERVE = 3'd5
  } arbstate_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin pick. The pointer only matters
//               when both requesters are active; the caller owns the
//               pointer and flips it after each grant.
// Ports       : req[1:0] - request lines
//               ptr      - preferred requester on a tie
//               winner   - index of the selected requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       winner
);

  always_comb begin
    if (req == 2'b11) begin
      winner = ptr;
    end else begin
      // Single requester (or none): requester 1 wins only if it alone asks.
      winner = req[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/coherence_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : coherence_arbiter
// Description : RAM-port arbiter and snoop coherence controller for two
//               cores. Data traffic beats instruction traffic. A coherent
//               dcache request first snoops the other dcache; a dirty copy
//               is written back before the requester is served.
// Ports       : CLK, nRST              - clock, async active-low reset
//               iREN/iaddr/iwait/iload - icache side, per core
//               dREN/dWEN/daddr/dstore/dwait/dload - dcache side, per core
//               cctrans/ccwrite        - coherent request / snoop response
//               ccwait/ccinv/ccsnoopaddr - snoop control toward dcaches
//               ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate - RAM port
// Revision    : 1.0 - initial release
// ============================================================================
module coherence_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                       CLK,
  input  logic                       nRST,
  // icache side
  input  logic [CPUS-1:0]            iREN,
  input  logic [CPUS-1:0][31:0]      iaddr,
  output logic [CPUS-1:0]            iwait,
  output logic [CPUS-1:0][31:0]      iload,
  // dcache side
  input  logic [CPUS-1:0]            dREN,
  input  logic [CPUS-1:0]            dWEN,
  input  logic [CPUS-1:0][31:0]      daddr,
  input  logic [CPUS-1:0][31:0]      dstore,
  output logic [CPUS-1:0]            dwait,
  output logic [CPUS-1:0][31:0]      dload,
  // coherence
  input  logic [CPUS-1:0]            cctrans,
  input  logic [CPUS-1:0]            ccwrite,
  output logic [CPUS-1:0]            ccwait,
  output logic [CPUS-1:0]            ccinv,
  output logic [CPUS-1:0][31:0]      ccsnoopaddr,
  // RAM port
  output logic                       ramREN,
  output logic                       ramWEN,
  output word_t                      ramaddr,
  output word_t                      ramstore,
  input  word_t                      ramload,
  input  ramstate_t                  ramstate
);

  // Registered state
  arbstate_t state, state_n;
  logic      r, r_n;                   // served core
  word_t     snoop_addr, snoop_addr_n; // latched snoop address
  logic      snoop_wr, snoop_wr_n;     // requester's write intent
  logic      dptr, dptr_n;
  logic      iptr, iptr_n;
  logic      snooped, snooped_n;       // current DSERVE followed a snoop
  logic      wb_first, wb_first_n;     // first cycle of CCWB
  logic      wb_cnt, wb_cnt_n;         // writeback words already done

  logic      o;                        // the snooped (other) core
  logic      cc_win, wb_win, i_win;
  logic      ram_done;

  assign o        = ~r;
  assign ram_done = (ramstate == ACCESS);

  rr_arbiter2 u_cc_arb (.req(cctrans), .ptr(dptr), .winner(cc_win));
  rr_arbiter2 u_wb_arb (.req(dWEN),    .ptr(dptr), .winner(wb_win));
  rr_arbiter2 u_i_arb  (.req(iREN),    .ptr(iptr), .winner(i_win));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      r          <= 1'b0;
      snoop_addr <= '0;
      snoop_wr   <= 1'b0;
      dptr       <= 1'b0;
      iptr       <= 1'b0;
      snooped    <= 1'b0;
      wb_first   <= 1'b0;
      wb_cnt     <= 1'b0;
    end else begin
      state      <= state_n;
      r          <= r_n;
      snoop_addr <= snoop_addr_n;
      snoop_wr   <= snoop_wr_n;
      dptr       <= dptr_n;
      iptr       <= iptr_n;
      snooped    <= snooped_n;
      wb_first   <= wb_first_n;
      wb_cnt     <= wb_cnt_n;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    r_n          = r;
    snoop_addr_n = snoop_addr;
    snoop_wr_n   = snoop_wr;
    dptr_n       = dptr;
    iptr_n       = iptr;
    snooped_n    = snooped;
    wb_first_n   = 1'b0;
    wb_cnt_n     = wb_cnt;

    case (state)
      IDLE: begin
        if (|cctrans) begin
          r_n          = cc_win;
          dptr_n       = ~cc_win;
          snoop_addr_n = daddr[cc_win];
          snoop_wr_n   = ccwrite[cc_win];
          snooped_n    = 1'b1;
          state_n      = SNOOP0;
        end else if (|dWEN) begin
          r_n       = wb_win;
          dptr_n    = ~wb_win;
          snooped_n = 1'b0;
          state_n   = DSERVE;
        end else if (|iREN) begin
          r_n     = i_win;
          iptr_n  = ~i_win;
          state_n = ISERVE;
        end
      end

      SNOOP0: state_n = SNOOP1;

      SNOOP1: begin
        if (cctrans[o] && ccwrite[o]) begin
          wb_first_n = 1'b1;
          wb_cnt_n   = 1'b0;
          state_n    = CCWB;
        end else begin
          state_n = DSERVE;
        end
      end

      CCWB: begin
        // A "dirty" reply without a writeback behind it comes from a core
        // that is itself stuck requesting; nothing to write, move on.
        if (wb_first && !dWEN[o]) begin
          state_n = DSERVE;
        end else if (ram_done) begin
          wb_cnt_n = ~wb_cnt;
          if (wb_cnt) begin
            state_n = DSERVE;
          end
        end
      end

      DSERVE: begin
        if (!dREN[r] && !dWEN[r] && !cctrans[r]) begin
          state_n = IDLE;
        end
      end

      ISERVE: begin
        if (ram_done) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    iwait          = '1;
    dwait          = '1;
    ccwait         = '0;
    ccinv          = '0;
    ccsnoopaddr    = '0;
    ccsnoopaddr[o] = snoop_addr;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = '0;
    ramstore       = '0;

    case (state)
      SNOOP0, SNOOP1: begin
        ccwait[o] = 1'b1;
        ccinv[o]  = snoop_wr;
      end

      CCWB: begin
        ccwait[o] = 1'b1;
        ramWEN    = dWEN[o];
        ramaddr   = daddr[o];
        ramstore  = dstore[o];
        if (ram_done) dwait[o] = 1'b0;
      end

      DSERVE: begin
        // On the requester side ccinv acts as the coherence grant.
        ccinv[r] = snooped;
        ramREN   = dREN[r];
        ramWEN   = dWEN[r] & ~dREN[r];
        ramaddr  = daddr[r];
        ramstore = dstore[r];
        if (ram_done) dwait[r] = 1'b0;
      end

      ISERVE: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r];
        if (ram_done) iwait[r] = 1'b0;
      end

      default: ;
    endcase
  end

  assign dload = {CPUS{ramload}};
  assign iload = {CPUS{ramload}};

endmodule
`default_nettype wire

// File: tb/tb_coherence_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_coherence_arbiter
// Description : Directed bench for coherence_arbiter with a small RAM model
//               (two-cycle latency, optional forced state) and an in-order
//               scoreboard of expected RAM transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coherence_arbiter;
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;

  localparam logic [31:0] PAT = 32'hDEAD_0000;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  word_t            ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  always #5 CLK = ~CLK;

  coherence_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  // ---------------- RAM model: ACCESS on the 2nd enabled cycle -------------
  logic      ovr_en;
  ramstate_t ovr_val;
  logic      ram_cnt;
  logic      ram_en;

  assign ram_en  = ramREN | ramWEN;
  assign ramload = ramaddr ^ PAT;

  always_comb begin
    if (ovr_en)        ramstate = ovr_val;
    else if (!ram_en)  ramstate = FREE;
    else if (ram_cnt)  ramstate = ACCESS;
    else               ramstate = BUSY;
  end

  always_ff @(posedge CLK) begin
    if (ovr_en || !ram_en || ramstate == ACCESS) ram_cnt <= 1'b0;
    else                                         ram_cnt <= 1'b1;
  end

  // ---------------- checking ----------------------------------------------
  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        wen;
    logic        icache;
    logic        core;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [1:0] mon_m;

  task automatic expect_ram(input logic wen, input logic icache, input logic core,
                            input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.wen = wen; e.icache = icache; e.core = core; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Every RAM ACCESS cycle must match the oldest expected transaction; on all
  // other cycles no cache may see its wait dropped.
  always @(negedge CLK) begin
    if (ramstate == ACCESS) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_access", 32'(ramaddr), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        mon_m = mon_e.core ? 2'b01 : 2'b10;
        check("sb_enables", 32'({ramREN, ramWEN}), 32'({~mon_e.wen, mon_e.wen}));
        check("sb_addr", ramaddr, mon_e.addr);
        if (mon_e.wen)         check("sb_store", ramstore, mon_e.data);
        else if (mon_e.icache) check("sb_iload", iload[mon_e.core], mon_e.data);
        else                   check("sb_dload", dload[mon_e.core], mon_e.data);
        check("sb_waits", 32'({dwait, iwait}),
              mon_e.icache ? 32'({2'b11, mon_m}) : 32'({mon_m, 2'b11}));
      end
    end else begin
      check("waits_high", 32'({dwait, iwait}), 32'hF);
    end
  end

  // ---------------- helpers ------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dword(input int c);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (dwait[c] !== 1'b0 && n < 30);
    check("dwait_low", 32'(dwait[c]), 32'h0);
  endtask

  task automatic wait_iword(input int c);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (iwait[c] !== 1'b0 && n < 30);
    check("iwait_low", 32'(iwait[c]), 32'h0);
  endtask

  task automatic serve_d(input int c, input logic [31:0] base,
                         input logic [31:0] dbase, input int n);
    for (int i = 0; i < n; i++) begin
      daddr[c]  = base + 32'(4 * i);
      dstore[c] = dbase + 32'(4 * i);
      wait_dword(c);
      tick();
    end
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ---------------------------------------
  initial begin
    nRST = 1'b0;
    ovr_en = 1'b0;
    ovr_val = FREE;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Reset state
    @(negedge CLK);
    check("rst_dwait", 32'(dwait), 32'h3);
    check("rst_iwait", 32'(iwait), 32'h3);
    check("rst_cc", 32'({ccwait, ccinv}), 32'h0);
    check("rst_ram_en", 32'({ramREN, ramWEN}), 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_snoop0", ccsnoopaddr[0], 32'h0);
    check("rst_snoop1", ccsnoopaddr[1], 32'h0);

    // Core0 coherent read, core1 clean
    tick();
    expect_ram(1'b0, 1'b0, 1'b0, 32'h100, 32'h100 ^ PAT);
    expect_ram(1'b0, 1'b0, 1'b0, 32'h104, 32'h104 ^ PAT);
    cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h100;
    @(negedge CLK);
    check("t1_idle_ccwait", 32'(ccwait), 32'h0);
    @(negedge CLK);
    check("t1_s0_ccwait", 32'(ccwait), 32'h2);
    check("t1_s0_ccinv", 32'(ccinv), 32'h0);
    check("t1_s0_snoopaddr", ccsnoopaddr[1], 32'h100);
    @(negedge CLK);
    check("t1_s1_ccwait", 32'(ccwait), 32'h2);
    check("t1_s1_ccinv", 32'(ccinv), 32'h0);
    @(negedge CLK);
    check("t1_ds_ccwait", 32'(ccwait), 32'h0);
    check("t1_ds_ccinv", 32'(ccinv), 32'h1);
    check("t1_ds_ram_en", 32'({ramREN, ramWEN}), 32'h2);
    check("t1_ds_addr", ramaddr, 32'h100);
    serve_d(0, 32'h100, 32'h0, 2);
    cctrans[0] = 1'b0; dREN[0] = 1'b0;
    tick();
    @(negedge CLK);
    check("t1_back_idle", 32'({ccinv, ramREN, ramWEN}), 32'h0);

    // Core1 write-upgrade, core0 dirty
    tick();
    expect_ram(1'b1, 1'b0, 1'b0, 32'h200, 32'hCAFE_0200);
    expect_ram(1'b1, 1'b0, 1'b0, 32'h204, 32'hCAFE_0204);
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200;
    @(negedge CLK);
    @(negedge CLK);
    check("t2_s0_ccwait", 32'(ccwait), 32'h1);
    check("t2_s0_ccinv", 32'(ccinv), 32'h1);
    check("t2_s0_snoopaddr", ccsnoopaddr[0], 32'h200);
    tick();
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dWEN[0] = 1'b1;
    daddr[0] = 32'h200; dstore[0] = 32'hCAFE_0200;
    @(negedge CLK);
    check("t2_s1_ccinv", 32'(ccinv), 32'h1);
    @(negedge CLK);
    check("t2_wb_ccwait", 32'(ccwait), 32'h1);
    check("t2_wb_ram_en", 32'({ramREN, ramWEN}), 32'h1);
    check("t2_wb_addr", ramaddr, 32'h200);
    serve_d(0, 32'h200, 32'hCAFE_0200, 2);
    cctrans[0] = 1'b0; ccwrite[0] = 1'b0; dWEN[0] = 1'b0;
    @(negedge CLK);
    check("t2_ds_ccinv", 32'(ccinv), 32'h2);
    check("t2_ds_ccwait", 32'(ccwait), 32'h0);
    check("t2_ds_ram_en", 32'({ramREN, ramWEN}), 32'h0);
    tick();
    cctrans[1] = 1'b0; ccwrite[1] = 1'b0;
    tick();
    tick();

    // Simultaneous cctrans after reset
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    expect_ram(1'b0, 1'b0, 1'b0, 32'h300, 32'h300 ^ PAT);
    expect_ram(1'b0, 1'b0, 1'b0, 32'h304, 32'h304 ^ PAT);
    expect_ram(1'b0, 1'b0, 1'b1, 32'h400, 32'h400 ^ PAT);
    expect_ram(1'b0, 1'b0, 1'b1, 32'h404, 32'h404 ^ PAT);
    cctrans = 2'b11; dREN = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h400;
    @(negedge CLK);
    @(negedge CLK);
    check("t3_first_snoop", 32'(ccwait), 32'h2);
    check("t3_first_addr", ccsnoopaddr[1], 32'h300);
    serve_d(0, 32'h300, 32'h0, 2);
    cctrans[0] = 1'b0; dREN[0] = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("t3_second_snoop", 32'(ccwait), 32'h1);
    check("t3_second_addr", ccsnoopaddr[0], 32'h400);
    serve_d(1, 32'h400, 32'h0, 2);
    cctrans[1] = 1'b0; dREN[1] = 1'b0;
    tick();
    tick();

    // Data beats icache; icache 0 before icache 1
    expect_ram(1'b0, 1'b0, 1'b0, 32'h500, 32'h500 ^ PAT);
    expect_ram(1'b0, 1'b0, 1'b0, 32'h504, 32'h504 ^ PAT);
    expect_ram(1'b0, 1'b1, 1'b0, 32'h600, 32'h600 ^ PAT);
    expect_ram(1'b0, 1'b1, 1'b1, 32'h700, 32'h700 ^ PAT);
    cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h500;
    iREN = 2'b11; iaddr[0] = 32'h600; iaddr[1] = 32'h700;
    serve_d(0, 32'h500, 32'h0, 2);
    cctrans[0] = 1'b0; dREN[0] = 1'b0;
    wait_iword(0);
    tick();
    iREN[0] = 1'b0;
    wait_iword(1);
    tick();
    iREN[1] = 1'b0;
    tick();

    // RAM held BUSY then ERROR during a plain writeback
    ovr_en = 1'b1; ovr_val = BUSY;
    dWEN[0] = 1'b1; daddr[0] = 32'h800; dstore[0] = 32'h1234_5678;
    tick();
    for (int i = 0; i < 6; i++) begin
      ovr_val = (i < 4) ? BUSY : ERROR;
      @(negedge CLK);
      check("t5_dwait_held", 32'(dwait), 32'h3);
      check("t5_still_writing", 32'({ramREN, ramWEN, ramaddr[15:0]}), 32'h1_0800);
      tick();
    end
    expect_ram(1'b1, 1'b0, 1'b0, 32'h800, 32'h1234_5678);
    ovr_en = 1'b0;
    wait_dword(0);
    tick();
    dWEN[0] = 1'b0;
    tick();
    tick();

    // Reset in the middle of a snoop writeback
    cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h900;
    @(negedge CLK);
    @(negedge CLK);
    tick();
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dWEN[0] = 1'b1;
    daddr[0] = 32'h900; dstore[0] = 32'h0000_BEEF;
    @(negedge CLK);
    @(negedge CLK);
    check("t6_in_ccwb", 32'({ccwait, ramREN, ramWEN}), 32'h5);
    #1;
    nRST = 1'b0;
    clear_inputs();
    #1;
    check("t6_async_ram_en", 32'({ramREN, ramWEN}), 32'h0);
    check("t6_async_cc", 32'({ccwait, ccinv}), 32'h0);
    check("t6_async_waits", 32'({dwait, iwait}), 32'hF);
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    check("t6_idle_ram", 32'({ramREN, ramWEN, ccwait}), 32'h0);
    check("t6_idle_addr", ramaddr, 32'h0);
    tick();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coherence_arbiter.md
# coherence_arbiter

Bus arbiter and snoop-based coherence controller between two cores' caches and the single RAM port. It grants RAM to one dcache or icache at a time; data traffic has priority over instruction traffic. Before granting a coherent dcache miss or write-upgrade, it snoops the other dcache and lets a dirty copy write back to RAM first. It sits under the per-core caches and above the RAM model in the multicore memory subsystem.

## Interface
- CPUS, 2, number of cores; only 2 is supported.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  [1:0]  icache read request per core.
- iaddr  in  [1:0][31:0]  icache address.
- iwait  out  [1:0]  0 for the cycle the icache's word is valid.
- iload  out  [1:0][31:0]  instruction word.
- dREN, dWEN  in  [1:0]  dcache read and write requests.
- daddr, dstore  in  [1:0][31:0]  dcache address and write data.
- dwait  out  [1:0]  0 for the cycle the dcache's access completes.
- dload  out  [1:0][31:0]  dcache read data.
- cctrans  in  [1:0]  coherent transaction request, or snoop response.
- ccwrite  in  [1:0]  write intent with cctrans, or dirty flag in a snoop response.
- ccwait  out  [1:0]  snoop in progress on this cache.
- ccinv  out  [1:0]  invalidate (snooped side) or grant (requester side).
- ccsnoopaddr  out  [1:0][31:0]  snoop address.
- ramREN, ramWEN  out  1  RAM read and write enables.
- ramaddr, ramstore  out  32  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE, BUSY, ACCESS, ERROR; ERROR is handled as BUSY.

## Operation
- Registered state: FSM state, owner r (1 bit), latched snoop address A, write intent W, round-robin pointers dptr and iptr.
- In every state, ccsnoopaddr[o] = A, where o = ~r.
- IDLE, evaluated in priority order:
  - If any cctrans is asserted: r = round-robin winner (ties broken by dptr, which then flips to ~r); A = daddr[r]; W = ccwrite[r]; go to SNOOP0.
  - Else if any dWEN (writeback or flush): r = round-robin winner; go to DSERVE.
  - Else if any iREN: r = round-robin winner via iptr; go to ISERVE.
- SNOOP0: ccwait[o]=1; ccinv[o]=W. Next state is SNOOP1.
- SNOOP1: ccwait[o]=1; ccinv[o]=W. Sample o's response:
  - cctrans[o] & ccwrite[o] → CCWB.
  - Otherwise → DSERVE.
- CCWB: ccwait[o]=1; RAM follows o's dWEN, daddr and dstore.
  - dWEN[o]=0 on the first CCWB cycle is a spurious dirty response; go to DSERVE.
  - Otherwise count completed words (ramstate==ACCESS); after the 2nd word, go to DSERVE.
- DSERVE: ccinv[r]=1 only if entered from SNOOP1 or CCWB. RAM follows r's request; dREN takes precedence over dWEN. Return to IDLE on the first cycle with dREN[r], dWEN[r] and cctrans[r] all 0.
- ISERVE: RAM reads iaddr[r]. Return to IDLE on the ACCESS cycle.
- dwait[c] / iwait[c] = 0 only when c is the served cache in CCWB, DSERVE or ISERVE and ramstate==ACCESS; otherwise 1.
- dload and iload are always driven from ramload.
- Reset values:
  - Outputs: all waits = 1; ccwait, ccinv, ramREN, ramWEN = 0; addresses and data = 0.
  - Registers: state = IDLE; r = 0; dptr = 0; iptr = 0; A = 0.

## Timing
- Snoop overhead is a fixed 2 cycles (SNOOP0, SNOOP1) before DSERVE when no writeback is needed.
- RAM enables are combinational from the current state and the served request. There is no added cycle inside serve states.
- A clean coherent 2-word load takes 3 + 2·(RAM latency) cycles from IDLE.
- Requests arriving while not in IDLE stay pending; requesters hold them.
- Simultaneous cctrans from both cores: the dptr winner is served first, and the other core is snooped. A loser stuck in its own request state is handled by the spurious-writeback rule.
- Reset asserted mid-transaction: outputs return to reset values asynchronously and no RAM enable remains asserted. A partially written block is not replayed.

## Structure
- arbstate_t (IDLE, SNOOP0, SNOOP1, CCWB, DSERVE, ISERVE) goes in diaosi_types_pkg.
- word_t and ramstate_t come from cpu_types_pkg.
- One sub-module, rr_arbiter2: inputs req[1:0] and ptr; outputs winner; used for both the data and instruction arbitration.

## Test plan
- Core0 coherent read (cctrans, dREN, daddr 0x100), other cache clean: ccwait[1] high for exactly 2 cycles; ccinv[1]=0; ccinv[0]=1 in DSERVE; ramREN at 0x100 then 0x104.
- Core1 write-upgrade (cctrans, ccwrite, 0x200); core0 responds dirty: ccinv[0]=1; RAM writes 0x200 and 0x204 from core0's dstore; then ccinv[1]=1.
- Both dcaches assert cctrans in the same cycle after reset: core0 is served first; dptr=1; core1 is served next.
- dREN[0], iREN[1] and iREN[0] all pending: data is served first, then icache 0, then icache 1. Each iwait is low for exactly one ACCESS cycle.
- ramstate held BUSY for 4 cycles, then ERROR for 2 cycles: dwait stays 1 throughout and no state advance occurs.
- nRST pulsed low during CCWB: next cycle is IDLE, ramWEN=0, all waits=1, ccwait=0.
